// File: rtl/tdm_demux_4_if.sv
// Bundle between the link receiver (master) and the TDM demultiplexer (slave):
// slot samples in, rebuilt four-channel frame and alignment status out.
interface tdm_demux_4_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic             frame_valid;
  logic             locked;
  logic             sync_err;
  logic [1:0]       slot;

  modport master (
    output din, din_valid, sync,
    input  y0, y1, y2, y3, frame_valid, locked, sync_err, slot
  );

  modport slave (
    input  din, din_valid, sync,
    output y0, y1, y2, y3, frame_valid, locked, sync_err, slot
  );
endinterface

// File: rtl/tdm_demux_4.sv
// Four-slot TDM demultiplexer: hunts for slot-0 sync, collects one sample per
// valid beat and publishes a registered four-channel frame with a one-cycle strobe.
module tdm_demux_4 #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux_4_if.slave io
);

  localparam int unsigned MW = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic             fv_q, fv_d;
  logic             lk_q, lk_d;
  logic             se_q, se_d;
  logic             miss_ok;

  assign miss_ok = (32'(miss_q) + 32'd1) < MISS_LIMIT;

  // Next-state and output computation; strobes default low every cycle.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;

    if (io.din_valid) begin
      if (state_q == HUNT) begin
        if (io.sync) begin
          sh0_d   = io.din;
          slot_d  = 2'd1;
          miss_d  = '0;
          state_d = LOCKED;
        end
      end else if (io.sync && (slot_q != 2'd0)) begin
        // Misplaced sync: drop the partial frame and realign on this beat.
        se_d   = 1'b1;
        sh0_d  = io.din;
        slot_d = 2'd1;
        miss_d = '0;
      end else begin
        unique case (slot_q)
          2'd0: begin
            if (io.sync) begin
              sh0_d  = io.din;
              slot_d = 2'd1;
              miss_d = '0;
            end else if (miss_ok) begin
              sh0_d  = io.din;
              slot_d = 2'd1;
              miss_d = MW'(miss_q + MW'(1));
            end else begin
              state_d = HUNT;
              slot_d  = 2'd0;
              miss_d  = '0;
            end
          end
          2'd1: begin
            sh1_d  = io.din;
            slot_d = 2'd2;
          end
          2'd2: begin
            sh2_d  = io.din;
            slot_d = 2'd3;
          end
          default: begin
            y0_d   = sh0_q;
            y1_d   = sh1_q;
            y2_d   = sh2_q;
            y3_d   = io.din;
            fv_d   = 1'b1;
            slot_d = 2'd0;
          end
        endcase
      end
    end

    lk_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
      miss_q  <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      fv_q    <= 1'b0;
      lk_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      fv_q    <= fv_d;
      lk_q    <= lk_d;
      se_q    <= se_d;
    end
  end

  assign io.y0          = y0_q;
  assign io.y1          = y1_q;
  assign io.y2          = y2_q;
  assign io.y3          = y3_q;
  assign io.frame_valid = fv_q;
  assign io.locked      = lk_q;
  assign io.sync_err    = se_q;
  assign io.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed table-driven bench for tdm_demux_4 (WIDTH=4, MISS_LIMIT=2).
module tb_tdm_demux_4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_demux_4_if #(.WIDTH(4)) io ();

  tdm_demux_4 #(.WIDTH(4), .MISS_LIMIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  din;
    logic        vld;
    logic        syn;
    logic [15:0] y;
    logic        fv;
    logic        lk;
    logic        se;
    logic [1:0]  slot;
    int          gap;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [3:0] d, logic vl, logic s, logic [15:0] y,
                              logic fv, logic lk, logic se, logic [1:0] sl, int gap);
    vec_t r;
    r.din = d; r.vld = vl; r.syn = s; r.y = y;
    r.fv = fv; r.lk = lk; r.se = se; r.slot = sl; r.gap = gap;
    return r;
  endfunction

  function automatic logic [20:0] outs();
    return {io.y0, io.y1, io.y2, io.y3, io.frame_valid, io.locked, io.sync_err, io.slot};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got y=%h fv=%b lk=%b se=%b slot=%0d, expected y=%h fv=%b lk=%b se=%b slot=%0d",
               name, got[20:5], got[4], got[3], got[2], got[1:0],
               exp[20:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic idle(input int n);
    io.din_valid = 1'b0;
    io.sync      = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    io.din = '0; io.din_valid = 1'b0; io.sync = 1'b0;

    // HUNT: two unsynced beats ignored, then frame A..D
    tbl.push_back(mk(4'h7, 1, 0, 16'h0000, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(4'h6, 1, 0, 16'h0000, 0, 0, 0, 2'd0, 0));
    tbl.push_back(mk(4'hA, 1, 1, 16'h0000, 0, 1, 0, 2'd1, 0));
    tbl.push_back(mk(4'hB, 1, 0, 16'h0000, 0, 1, 0, 2'd2, 0));
    tbl.push_back(mk(4'hC, 1, 0, 16'h0000, 0, 1, 0, 2'd3, 0));
    tbl.push_back(mk(4'hD, 1, 0, 16'hABCD, 1, 1, 0, 2'd0, 1));
    // back-to-back frame 1..4
    tbl.push_back(mk(4'h1, 1, 1, 16'hABCD, 0, 1, 0, 2'd1, 0));
    tbl.push_back(mk(4'h2, 1, 0, 16'hABCD, 0, 1, 0, 2'd2, 0));
    tbl.push_back(mk(4'h3, 1, 0, 16'hABCD, 0, 1, 0, 2'd3, 0));
    tbl.push_back(mk(4'h4, 1, 0, 16'h1234, 1, 1, 0, 2'd0, 1));
    // frame 5..8 with 3 idle cycles between beats
    tbl.push_back(mk(4'h5, 1, 1, 16'h1234, 0, 1, 0, 2'd1, 3));
    tbl.push_back(mk(4'h6, 1, 0, 16'h1234, 0, 1, 0, 2'd2, 3));
    tbl.push_back(mk(4'h7, 1, 0, 16'h1234, 0, 1, 0, 2'd3, 3));
    tbl.push_back(mk(4'h8, 1, 0, 16'h5678, 1, 1, 0, 2'd0, 2));
    // misplaced sync on slot 2 realigns; partial frame dropped
    tbl.push_back(mk(4'h1, 1, 1, 16'h5678, 0, 1, 0, 2'd1, 0));
    tbl.push_back(mk(4'h2, 1, 0, 16'h5678, 0, 1, 0, 2'd2, 0));
    tbl.push_back(mk(4'h9, 1, 1, 16'h5678, 0, 1, 1, 2'd1, 1));
    tbl.push_back(mk(4'hA, 1, 0, 16'h5678, 0, 1, 0, 2'd2, 0));
    tbl.push_back(mk(4'hB, 1, 0, 16'h5678, 0, 1, 0, 2'd3, 0));
    tbl.push_back(mk(4'hC, 1, 0, 16'h9ABC, 1, 1, 0, 2'd0, 0));
    // missing sync: first tolerated, second drops lock
    tbl.push_back(mk(4'h3, 1, 0, 16'h9ABC, 0, 1, 0, 2'd1, 0));
    tbl.push_back(mk(4'h4, 1, 0, 16'h9ABC, 0, 1, 0, 2'd2, 0));
    tbl.push_back(mk(4'h5, 1, 0, 16'h9ABC, 0, 1, 0, 2'd3, 0));
    tbl.push_back(mk(4'h6, 1, 0, 16'h3456, 1, 1, 0, 2'd0, 0));
    tbl.push_back(mk(4'h7, 1, 0, 16'h3456, 0, 0, 0, 2'd0, 1));
    // sync without din_valid is ignored
    tbl.push_back(mk(4'h9, 0, 1, 16'h3456, 0, 0, 0, 2'd0, 0));

    repeat (2) @(negedge clk);
    check("reset_state", outs(), 21'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      io.din = tbl[i].din; io.din_valid = tbl[i].vld; io.sync = tbl[i].syn;
      @(negedge clk);
      check($sformatf("row%0d", i), outs(),
            {tbl[i].y, tbl[i].fv, tbl[i].lk, tbl[i].se, tbl[i].slot});
      for (int g = 0; g < tbl[i].gap; g++) begin
        idle(1);
        check($sformatf("row%0d_gap%0d", i, g), outs(),
              {tbl[i].y, 1'b0, tbl[i].lk, 1'b0, tbl[i].slot});
      end
    end
    idle(1);

    // Reset mid-frame clears outputs before the next clock edge
    io.din = 4'h1; io.din_valid = 1'b1; io.sync = 1'b1;
    @(negedge clk);
    io.din = 4'h2; io.sync = 1'b0;
    @(negedge clk);
    check("pre_reset", outs(), {16'h3456, 1'b0, 1'b1, 1'b0, 2'd2});
    idle(0);
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 21'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unsynced frame after reset must not produce a frame
    for (int k = 0; k < 4; k++) begin
      io.din = 4'(k + 3); io.din_valid = 1'b1; io.sync = 1'b0;
      @(negedge clk);
      check($sformatf("post_reset_beat%0d", k), outs(), 21'd0);
    end
    idle(1);
    check("post_reset_idle", outs(), 21'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
